// File: rtl/adder_job_arbiter.sv
// adder_job_arbiter: shares one adder core among NREQ requesters.
// Arbitration is round-robin. One job is in flight at a time, and the result is
// returned to the requester that owns the job.
// Optional feature: define ADDER_ARB_TIMEOUT_EN to abort a job when the core
// stays silent for TIMEOUT_CYC cycles in WAIT. The response then carries rsp_err=1.
module adder_job_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                     ACLK,
  input  logic                     ARSTn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W:0]          rsp_data,
  output logic                     rsp_err,
  output logic                     core_start,
  output logic [DATA_W-1:0]        core_a,
  output logic [DATA_W-1:0]        core_b,
  input  logic                     core_busy,
  input  logic                     core_done,
  input  logic [DATA_W:0]          core_result
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("adder_job_arbiter: NREQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic               do_grant;
  logic [DATA_W-1:0]  grant_a;
  logic [DATA_W-1:0]  grant_b;
  logic               timeout_hit;

  // Round-robin search: indices above rr_ptr win first, then the search wraps to 0..rr_ptr
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_a     = '0;
    grant_b     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_found && (i > 32'(rr_ptr)) && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(i);
        grant_a     = req_a[i*DATA_W +: DATA_W];
        grant_b     = req_b[i*DATA_W +: DATA_W];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_found && (i <= 32'(rr_ptr)) && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(i);
        grant_a     = req_a[i*DATA_W +: DATA_W];
        grant_b     = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign do_grant = (state == S_IDLE) && grant_found && !core_busy;

`ifdef ADDER_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign timeout_hit = (state == S_WAIT) && !core_done && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_err     = err_q;

  // WAIT-cycle counter and abort flag; the flag follows rsp_data through RESP and the response cycle
  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  err_q <= 1'b0;
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (core_done)        err_q <= 1'b0;
          else if (timeout_hit) err_q <= 1'b1;
          else                  wait_cnt <= wait_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARSTn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; core_done outside WAIT is never looked at
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (do_grant) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (core_done || timeout_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs, operand latch, owner and round-robin pointer
  // rsp_data stays valid through RESP and is cleared only in the following IDLE cycle,
  // so it is still stable while the rsp_valid pulse is visible.
  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      core_start <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      owner      <= '0;
      rr_ptr     <= PTR_W'(NREQ - 1);
    end else begin
      req_ready  <= '0;
      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          rsp_valid <= '0;
          rsp_data  <= '0;
          if (do_grant) begin
            req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
            core_a    <= grant_a;
            core_b    <= grant_b;
            owner     <= grant_idx;
            rr_ptr    <= grant_idx;
          end
        end
        S_ISSUE: core_start <= 1'b1;
        S_WAIT: begin
          if (core_done)        rsp_data <= core_result;
          else if (timeout_hit) rsp_data <= '0;
        end
        S_RESP: begin
          rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << owner;
          core_a    <= '0;
          core_b    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_job_arbiter.sv
// Self-checking bench for adder_job_arbiter.
// It contains a behavioural adder core, a response scoreboard and one task per scenario.
module tb_adder_job_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam logic [DW:0] SPUR_VAL = 33'h1_2345_6789;

  logic                 ACLK = 1'b0;
  logic                 ARSTn = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_a = '0;
  logic [NREQ*DW-1:0]   req_b = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW:0]          rsp_data;
  logic                 rsp_err;
  logic                 core_start;
  logic [DW-1:0]        core_a;
  logic [DW-1:0]        core_b;
  logic                 core_busy = 1'b0;
  logic                 core_done = 1'b0;
  logic [DW:0]          core_result = '0;

  adder_job_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .ACLK(ACLK), .ARSTn(ARSTn),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_busy(core_busy), .core_done(core_done), .core_result(core_result)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int          owner;
    logic [DW:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_delay = 1;
  bit   core_en = 1'b1;
  bit   spur_issue = 1'b0;
  int   spur_idle_req = 0;
  int   spur_idle_done = 0;

  // Behavioural core. It answers core_start after done_delay cycles; done_delay=0 means done in the first WAIT cycle.
  task automatic core_model();
    forever begin
      @(negedge ACLK);
      core_done = 1'b0;
      if (spur_idle_req != spur_idle_done) begin
        spur_idle_done++;
        core_done   = 1'b1;
        core_result = SPUR_VAL;
      end else if (spur_issue && req_ready != '0) begin
        core_done   = 1'b1;
        core_result = SPUR_VAL;
      end else if (core_start && core_en) begin
        logic [DW:0] sum;
        sum = {1'b0, core_a} + {1'b0, core_b};
        if (done_delay > 0) begin
          @(negedge ACLK);
          checks++;
          if (core_start !== 1'b0) begin
            failures++;
            $display("FAIL start_pulse: core_start=%b one cycle later, required 0", core_start);
          end
          repeat (done_delay - 1) @(negedge ACLK);
        end
        core_done   = 1'b1;
        core_result = sum;
      end
    end
  endtask

  // Scoreboard: every response pulse is popped and compared against the expected owner, data and error.
  task automatic monitor();
    exp_t e;
    logic [NREQ-1:0] ev;
    forever begin
      @(negedge ACLK);
      if (rsp_valid !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: rsp_valid=%b rsp_data=%h, required no response", rsp_valid, rsp_data);
        end else begin
          e  = sb.pop_front();
          ev = 4'b0001 << e.owner;
          if (rsp_valid !== ev || rsp_data !== e.data || rsp_err !== e.err) begin
            failures++;
            $display("FAIL rsp: rsp_valid=%b data=%h err=%b, required rsp_valid=%b data=%h err=%b",
                     rsp_valid, rsp_data, rsp_err, ev, e.data, e.err);
          end
        end
      end
    end
  endtask

  task automatic wait_ready(input int limit, output int cyc);
    cyc = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge ACLK);
      if (req_ready !== '0) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic wait_drain(output int left);
    for (int n = 0; n < 80 && sb.size() != 0; n++) @(negedge ACLK);
    left = sb.size();
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    ARSTn = 1'b0;
    repeat (2) @(negedge ACLK);
    ARSTn = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARSTn = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_a, core_b} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rsp_valid=%b data=%h err=%b start=%b a=%h b=%h, required all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_a, core_b);
    end
    ARSTn = 1'b1;
    repeat (2) @(negedge ACLK);
    checks++;
    if ({req_ready, rsp_valid, core_start} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: ready=%b rsp_valid=%b start=%b, required 0", req_ready, rsp_valid, core_start);
    end
  endtask

  task automatic test_single();
    int cyc, lat;
    bit held;
    done_delay = 4;
    req_a[0 +: DW] = 32'd5;
    req_b[0 +: DW] = 32'd7;
    sb.push_back('{0, 33'd12, 1'b0});
    req_valid = 4'b0001;
    wait_ready(10, cyc);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant: req_ready=%b, required 0001", req_ready);
    end
    req_valid = '0;
    @(negedge ACLK);
    checks++;
    if (core_start !== 1'b1 || core_a !== 32'd5 || core_b !== 32'd7) begin
      failures++;
      $display("FAIL single_issue: start=%b a=%0d b=%0d, required 1,5,7", core_start, core_a, core_b);
    end
    lat = -1;
    held = 1'b1;
    for (int n = 2; n <= 40; n++) begin
      @(negedge ACLK);
      if (rsp_valid !== '0) begin
        lat = n;
        break;
      end
      if (core_a !== 32'd5 || core_b !== 32'd7) held = 1'b0;
    end
    checks++;
    if (lat != 7) begin
      failures++;
      $display("FAIL single_latency: %0d cycles from req_ready to rsp_valid, required 7", lat);
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL operand_hold: core_a/core_b changed before response, required stable 5/7");
    end
    @(negedge ACLK);
  endtask

  task automatic test_round_robin();
    int cyc, left;
    logic [DW-1:0] a_k [5];
    logic [DW-1:0] b_k [5];
    logic [NREQ-1:0] eg;
    do_reset();
    done_delay = 1;
    for (int k = 0; k < 5; k++) begin
      a_k[k] = 32'h0100_0000 * (k + 1) + 32'(k);
      b_k[k] = 32'hF0FF_FFFF + 32'(k * 3);
      sb.push_back('{k % 4, {1'b0, a_k[k]} + {1'b0, b_k[k]}, 1'b0});
    end
    for (int g = 0; g < 4; g++) begin
      req_a[g*DW +: DW] = a_k[g];
      req_b[g*DW +: DW] = b_k[g];
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ready(20, cyc);
      eg = 4'b0001 << (k % 4);
      checks++;
      if (req_ready !== eg) begin
        failures++;
        $display("FAIL rr_grant%0d: req_ready=%b, required %b", k, req_ready, eg);
      end
      if (k == 0) begin
        req_a[0 +: DW] = a_k[4];
        req_b[0 +: DW] = b_k[4];
      end else begin
        req_valid[k % 4] = 1'b0;
      end
    end
    wait_drain(left);
    checks++;
    if (left != 0) begin
      failures++;
      $display("FAIL rr_drain: %0d responses outstanding, required 0", left);
    end
  endtask

  task automatic test_carry();
    int cyc, left;
    done_delay = 2;
    req_a[1*DW +: DW] = 32'hFFFF_FFFF;
    req_b[1*DW +: DW] = 32'h0000_0001;
    sb.push_back('{1, 33'h1_0000_0000, 1'b0});
    req_valid = 4'b0010;
    wait_ready(10, cyc);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL carry_grant: req_ready=%b, required 0010", req_ready);
    end
    req_valid = '0;
    req_a[3*DW +: DW] = 32'hFFFF_FFFF;
    req_b[3*DW +: DW] = 32'hFFFF_FFFF;
    sb.push_back('{3, 33'h1_FFFF_FFFE, 1'b0});
    req_valid = 4'b1000;
    wait_ready(20, cyc);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL carry_grant2: req_ready=%b, required 1000", req_ready);
    end
    req_valid = '0;
    wait_drain(left);
    checks++;
    if (left != 0) begin
      failures++;
      $display("FAIL carry_drain: %0d responses outstanding, required 0", left);
    end
  endtask

  task automatic test_back_to_back();
    int last_ready, granted, rsps;
    done_delay = 0;
    for (int j = 0; j < 3; j++)
      sb.push_back('{2, {1'b0, 32'h8000_0000 + 32'(j)} + {1'b0, 32'h8000_0000}, 1'b0});
    req_a[2*DW +: DW] = 32'h8000_0000;
    req_b[2*DW +: DW] = 32'h8000_0000;
    req_valid = 4'b0100;
    last_ready = -1;
    granted = 0;
    rsps = 0;
    for (int cyc = 0; cyc < 60 && rsps < 3; cyc++) begin
      @(negedge ACLK);
      if (req_ready !== '0) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          failures++;
          $display("FAIL b2b_grant: req_ready=%b, required 0100", req_ready);
        end
        if (last_ready >= 0) begin
          checks++;
          if (cyc - last_ready != 4) begin
            failures++;
            $display("FAIL b2b_gap: %0d cycles between grants, required 4", cyc - last_ready);
          end
        end
        last_ready = cyc;
        granted++;
        if (granted < 3) req_a[2*DW +: DW] = 32'h8000_0000 + 32'(granted);
        else req_valid = '0;
      end
      if (rsp_valid !== '0) begin
        rsps++;
        checks++;
        if (cyc - last_ready != 3) begin
          failures++;
          $display("FAIL b2b_latency: %0d cycles from req_ready to rsp_valid, required 3", cyc - last_ready);
        end
      end
    end
    checks++;
    if (rsps != 3) begin
      failures++;
      $display("FAIL b2b_count: %0d responses, required 3", rsps);
    end
    req_valid = '0;
    @(negedge ACLK);
  endtask

  task automatic test_spurious();
    int cyc, left;
    bit seen;
    done_delay = 2;
    spur_idle_req++;
    seen = 1'b0;
    repeat (4) begin
      @(negedge ACLK);
      if (rsp_valid !== '0 || req_ready !== '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL spurious_idle: activity after done in IDLE, required none");
    end
    spur_issue = 1'b1;
    req_a[0 +: DW] = 32'd10;
    req_b[0 +: DW] = 32'd20;
    sb.push_back('{0, 33'd30, 1'b0});
    req_valid = 4'b0001;
    wait_ready(10, cyc);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL spurious_grant: req_ready=%b, required 0001", req_ready);
    end
    req_valid = '0;
    wait_drain(left);
    spur_issue = 1'b0;
    checks++;
    if (left != 0) begin
      failures++;
      $display("FAIL spurious_drain: %0d responses outstanding, required 0", left);
    end
  endtask

  task automatic test_busy_reset();
    int cyc, left;
    bit seen;
    core_en = 1'b0;
    core_busy = 1'b1;
    req_valid = 4'b0100;
    seen = 1'b0;
    repeat (5) begin
      @(negedge ACLK);
      if (req_ready !== '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL busy_block: req_ready asserted while core_busy=1, required 0");
    end
    core_busy = 1'b0;
    wait_ready(5, cyc);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL busy_release_grant: req_ready=%b, required 0100", req_ready);
    end
    req_valid = '0;
    repeat (4) @(negedge ACLK);
    ARSTn = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_a, core_b} !== '0) begin
      failures++;
      $display("FAIL wait_reset_outputs: ready=%b rsp_valid=%b data=%h err=%b start=%b a=%h b=%h, required all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_a, core_b);
    end
    ARSTn = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge ACLK);
      if (rsp_valid !== '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_discard: response after reset in WAIT, required none");
    end
    core_en = 1'b1;
    done_delay = 1;
    req_a[0 +: DW] = 32'd1;
    req_b[0 +: DW] = 32'd2;
    req_a[2*DW +: DW] = 32'd40;
    req_b[2*DW +: DW] = 32'd2;
    sb.push_back('{0, 33'd3, 1'b0});
    sb.push_back('{2, 33'd42, 1'b0});
    req_valid = 4'b0101;
    wait_ready(10, cyc);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL ptr_after_reset: req_ready=%b, required 0001", req_ready);
    end
    req_valid[0] = 1'b0;
    wait_ready(20, cyc);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL grant_after_reset2: req_ready=%b, required 0100", req_ready);
    end
    req_valid = '0;
    wait_drain(left);
    checks++;
    if (left != 0) begin
      failures++;
      $display("FAIL reset_drain: %0d responses outstanding, required 0", left);
    end
  endtask

  task automatic test_timeout();
    int cyc, left;
    core_en = 1'b0;
    req_a[1*DW +: DW] = 32'd3;
    req_b[1*DW +: DW] = 32'd4;
`ifdef ADDER_ARB_TIMEOUT_EN
    begin
      int lat;
      sb.push_back('{1, 33'd0, 1'b1});
      req_valid = 4'b0010;
      wait_ready(10, cyc);
      checks++;
      if (req_ready !== 4'b0010) begin
        failures++;
        $display("FAIL timeout_grant: req_ready=%b, required 0010", req_ready);
      end
      req_valid = '0;
      @(negedge ACLK);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
        @(negedge ACLK);
        if (rsp_valid !== '0) begin
          lat = n;
          break;
        end
      end
      checks++;
      if (lat != 17) begin
        failures++;
        $display("FAIL timeout_latency: rsp_valid %0d cycles after core_start, required 17", lat);
      end
      spur_idle_req++;
      repeat (5) @(negedge ACLK);
    end
`else
    begin
      bit seen;
      sb.push_back('{1, SPUR_VAL, 1'b0});
      req_valid = 4'b0010;
      wait_ready(10, cyc);
      checks++;
      if (req_ready !== 4'b0010) begin
        failures++;
        $display("FAIL wait_grant: req_ready=%b, required 0010", req_ready);
      end
      req_valid = '0;
      seen = 1'b0;
      repeat (40) begin
        @(negedge ACLK);
        if (rsp_valid !== '0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
        failures++;
        $display("FAIL wait_forever: response without core_done, required none");
      end
      spur_idle_req++;
    end
`endif
    wait_drain(left);
    checks++;
    if (left != 0) begin
      failures++;
      $display("FAIL timeout_drain: %0d responses outstanding, required 0", left);
    end
    core_en = 1'b1;
  endtask

  initial begin
    fork
      core_model();
      monitor();
      begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_single();
    test_round_robin();
    test_carry();
    test_back_to_back();
    test_spurious();
    test_busy_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
